// File: rtl/dcache_resp_pkg.sv
// Shared definitions for the data-cache responder: bus widths and field offsets
// for both execute-stage buses, read FSM encoding and the posted-write entry layout.
package dcache_resp_pkg;

  localparam int WD_W = 106;
  localparam int RD_W = 34;

  // Request bus, MSB first:
  // {valid, op, addr, uncached, awstrb, wdata, cacop_en, cacop_code, cacop_addr}
  localparam int WD_VALID          = WD_W - 1;
  localparam int WD_OP             = WD_W - 2;
  localparam int WD_ADDR_LSB       = WD_W - 34;
  localparam int WD_UNCACHED       = WD_W - 35;
  localparam int WD_STRB_LSB       = WD_W - 39;
  localparam int WD_WDATA_LSB      = WD_W - 71;
  localparam int WD_CACOP_EN       = WD_W - 72;
  localparam int WD_CACOP_CODE_LSB = WD_W - 74;
  localparam int WD_CACOP_ADDR_LSB = 0;

  // Response bus: {ready, rvalid, rdata}
  localparam int RD_READY     = RD_W - 1;
  localparam int RD_RVALID    = RD_W - 2;
  localparam int RD_RDATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RESP     = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam int WBUF_ENTRY_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/dcache_wbuf.sv
// Posted-write FIFO: synchronous, power-of-two depth, push and pop may coincide
// (including when full), head entry visible combinationally.
module dcache_wbuf import dcache_resp_pkg::*; #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WBUF_ENTRY_W-1:0] push_data,
  input  logic                    pop,
  output logic [WBUF_ENTRY_W-1:0] head,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(WBUF_DEPTH);

  logic [WBUF_ENTRY_W-1:0] mem [WBUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          occ;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (occ == DEPTH_V);
  assign empty   = (occ == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dcache_resp.sv
// Blocking, in-order data-cache responder for the execute stage: reads go
// straight to memory through a small FSM, writes are posted into dcache_wbuf.
module dcache_resp import dcache_resp_pkg::*; #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WD_W-1:0] dcache_wdata_bus,
  output logic [RD_W-1:0] dcache_rdata_bus,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [31:0]     mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata
);

  logic        req_valid;
  logic        req_op;
  logic [31:0] req_addr;
  logic [3:0]  req_strb;
  logic [31:0] req_wdata;
  logic        req_cacop;
  logic        unused_fields;

  assign req_valid = dcache_wdata_bus[WD_VALID];
  assign req_op    = dcache_wdata_bus[WD_OP];
  assign req_addr  = dcache_wdata_bus[WD_ADDR_LSB +: 32];
  assign req_strb  = dcache_wdata_bus[WD_STRB_LSB +: 4];
  assign req_wdata = dcache_wdata_bus[WD_WDATA_LSB +: 32];
  assign req_cacop = dcache_wdata_bus[WD_CACOP_EN];

  // Every access goes to memory, so uncached and the cache-op payload carry no meaning here.
  assign unused_fields = ^{dcache_wdata_bus[WD_UNCACHED],
                           dcache_wdata_bus[WD_CACOP_CODE_LSB +: 2],
                           dcache_wdata_bus[WD_CACOP_ADDR_LSB +: 32],
                           req_addr[1:0]};

  rd_state_e   state;
  logic [31:0] rd_addr_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic                    ready;
  logic                    accept;
  logic                    wr_accept;
  logic                    rd_accept;
  logic                    drain;
  logic                    wb_full;
  logic                    wb_empty;
  logic [WBUF_ENTRY_W-1:0] wb_push_bits;
  logic [WBUF_ENTRY_W-1:0] wb_head_bits;
  wbuf_entry_t             wb_push_entry;
  wbuf_entry_t             wb_head;

  // Ready never looks at valid; reads wait for an empty buffer so they cannot overtake a posted write.
  always_comb begin
    ready = 1'b0;
    if (state == ST_IDLE) begin
      if (req_cacop)   ready = 1'b1;
      else if (req_op) ready = ~wb_full;
      else             ready = wb_empty;
    end
  end

  assign accept    = req_valid & ready;
  assign wr_accept = accept & ~req_cacop & req_op;
  assign rd_accept = accept & ~req_cacop & ~req_op;
  assign drain     = (state == ST_IDLE) & ~wb_empty;

  always_comb begin
    wb_push_entry      = '0;
    wb_push_entry.addr = {req_addr[31:2], 2'b00};
    wb_push_entry.strb = req_strb;
    wb_push_entry.data = req_wdata;
  end

  assign wb_push_bits = wb_push_entry;
  assign wb_head      = wbuf_entry_t'(wb_head_bits);

  dcache_wbuf #(
    .WBUF_DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_accept),
    .push_data (wb_push_bits),
    .pop       (drain & mem_gnt),
    .head      (wb_head_bits),
    .full      (wb_full),
    .empty     (wb_empty)
  );

  // Memory port: the read issue owns the port outside IDLE, the buffer head owns it in IDLE.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (state == ST_RD_ISSUE) begin
      mem_req  = 1'b1;
      mem_addr = rd_addr_q;
    end else if (drain) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_head.addr;
      mem_wstrb = wb_head.strb;
      mem_wdata = wb_head.data;
    end
  end

  // Read FSM; rvalid/rdata are registered so rdata is zero except in the RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_accept) state <= ST_RD_ISSUE;
        end
        ST_RD_ISSUE: begin
          if (mem_gnt) begin
            if (mem_rvalid) begin
              state    <= ST_RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= mem_rdata;
            end else begin
              state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            state    <= ST_RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= mem_rdata;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) rd_addr_q <= {req_addr[31:2], 2'b00};
  end

  always_comb begin
    dcache_rdata_bus                        = '0;
    dcache_rdata_bus[RD_READY]              = ready;
    dcache_rdata_bus[RD_RVALID]             = rvalid_q;
    dcache_rdata_bus[RD_RDATA_LSB +: 32]    = rdata_q;
  end

endmodule

// File: tb/tb_dcache_resp.sv
// Bench for dcache_resp: directed scenarios plus a randomized mix, checked
// against a program-order memory model and a reactive memory-port responder.
module tb_dcache_resp;

  logic         clk = 1'b0;
  logic         reset;
  logic [105:0] wbus;
  logic [33:0]  rbus;
  logic         mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrb;

  logic        req_valid, req_op, req_unc, req_cacop;
  logic [31:0] req_addr, req_wdata, req_cacop_addr;
  logic [3:0]  req_strb;
  logic [1:0]  req_cacop_code;

  assign wbus = {req_valid, req_op, req_addr, req_unc, req_strb, req_wdata,
                 req_cacop, req_cacop_code, req_cacop_addr};

  wire        rdy   = rbus[33];
  wire        rvld  = rbus[32];
  wire [31:0] rdata = rbus[31:0];

  dcache_resp #(.WBUF_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .dcache_wdata_bus (wbus),
    .dcache_rdata_bus (rbus),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wstrb        (mem_wstrb),
    .mem_wdata        (mem_wdata),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Program-order view (ref_mem) versus what actually reached the memory port (bmem).
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bmem    [int unsigned];
  logic [67:0] exp_wr[$];
  logic [31:0] exp_rdaddr[$];

  int gnt_mode = 0;     // 0 never, 1 always, 2 random
  int rl_fixed = 1;     // read data delay after grant; negative = random 0..3
  int cyc = 0;
  int wr_gnt_cyc = 0;
  int rd_gnt_cyc = 0;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5EED_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
    return dflt(a);
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    if (bmem.exists(a >> 2)) return bmem[a >> 2];
    return dflt(a);
  endfunction

  // Memory-port responder: grants, returns read data, checks write order and request stability.
  initial begin
    logic        g, rv, hold_prev;
    logic [67:0] prev_bus;
    logic [31:0] pend_addr;
    int          pend, lat;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    hold_prev = 0; prev_bus = '0; pend = -1; pend_addr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (hold_prev && !reset) begin
        check("mem_req_hold", 68'(mem_req), 68'(1'b1));
        check("mem_bus_hold", {mem_addr, mem_wstrb, mem_wdata}, prev_bus);
      end
      g = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
      mem_gnt = mem_req && g;
      rv = 0;
      if (pend >= 0) begin
        if (pend == 0) begin rv = 1; pend = -1; end
        else pend--;
      end
      if (mem_gnt && mem_we) begin
        wr_gnt_cyc = cyc;
        check("mem_wr_expected", 68'(exp_wr.size() != 0), 68'(1'b1));
        if (exp_wr.size() != 0)
          check("mem_wr_entry", {mem_addr, mem_wstrb, mem_wdata}, exp_wr.pop_front());
        bmem[mem_addr >> 2] = merge(bmem_rd(mem_addr), mem_wdata, mem_wstrb);
      end else if (mem_gnt) begin
        rd_gnt_cyc = cyc;
        check("mem_rd_expected", 68'(exp_rdaddr.size() != 0), 68'(1'b1));
        if (exp_rdaddr.size() != 0)
          check("mem_rd_addr", 68'(mem_addr), 68'(exp_rdaddr.pop_front()));
        pend_addr = mem_addr;
        lat = (rl_fixed >= 0) ? rl_fixed : $urandom_range(0, 3);
        if (lat == 0) rv = 1;
        else pend = lat - 1;
      end
      hold_prev  = mem_req && !mem_gnt;
      prev_bus   = {mem_addr, mem_wstrb, mem_wdata};
      mem_rvalid = rv;
      mem_rdata  = rv ? bmem_rd(pend_addr) : $urandom;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; req_cacop = 0; req_op = 0;
  endtask

  task automatic wr_try(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic acc);
    req_valid = 1; req_op = 1; req_cacop = 0;
    req_addr = a; req_strb = s; req_wdata = d; req_unc = 1'($urandom);
    #1;
    acc = rdy;
    if (acc) begin
      exp_wr.push_back({a[31:2], 2'b00, s, d});
      ref_mem[a >> 2] = merge(ref_rd(a), d, s);
    end
  endtask

  task automatic wr_wait(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input int max);
    logic acc;
    acc = 0;
    for (int i = 0; i < max && !acc; i++) begin
      step();
      wr_try(a, s, d, acc);
    end
    check("wr_accept_bound", 68'(acc), 68'(1'b1));
    step();
    idle();
  endtask

  task automatic rd_op(input logic [31:0] a, input int max, output int lat);
    logic        acc;
    logic [31:0] e;
    acc = 0;
    lat = -1;
    for (int i = 0; i < max && !acc; i++) begin
      step();
      req_valid = 1; req_op = 0; req_cacop = 0; req_addr = a; req_unc = 1'($urandom);
      #1;
      acc = rdy;
    end
    check("rd_accept_bound", 68'(acc), 68'(1'b1));
    if (!acc) begin idle(); return; end
    e = ref_rd(a);
    exp_rdaddr.push_back({a[31:2], 2'b00});
    for (int k = 1; k <= max; k++) begin
      step();
      if (k == 1) idle();
      if (rvld) begin lat = k; break; end
      check("rd_busy_ready", 68'(rdy), 68'(1'b0));
      check("rd_rdata_zero", 68'(rdata), 68'(0));
    end
    check("rd_resp_bound", 68'(lat > 0), 68'(1'b1));
    if (lat > 0) check("rd_data", 68'(rdata), 68'(e));
    step();
    check("rd_rvalid_pulse", 68'(rvld), 68'(1'b0));
  endtask

  task automatic wait_drain(input int max);
    logic done;
    done = 0;
    for (int i = 0; i < max && !done; i++) begin
      step();
      done = (exp_wr.size() == 0) && !mem_req;
    end
    check("drain_bound", 68'(done), 68'(1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   lat;
    logic [31:0] a;
    reset = 1;
    req_valid = 0; req_op = 0; req_unc = 0; req_cacop = 0; req_addr = 0; req_wdata = 0;
    req_cacop_addr = 0; req_strb = 0; req_cacop_code = 0;
    repeat (3) step();
    reset = 0;

    // First cycle after reset: ready for both operation kinds, outputs quiet.
    req_op = 1; #1;
    check("rst_ready_wr", 68'(rdy), 68'(1'b1));
    req_op = 0; #1;
    check("rst_ready_rd", 68'(rdy), 68'(1'b1));
    check("rst_rvalid", 68'(rvld), 68'(1'b0));
    check("rst_rdata", 68'(rdata), 68'(0));
    check("rst_mem_req", 68'(mem_req), 68'(1'b0));
    check("rst_occ", 68'(dut.u_wbuf.occ), 68'(0));

    // Single read with immediate grant and data one cycle later.
    gnt_mode = 1; rl_fixed = 1;
    ref_mem[32'h1000_0004 >> 2] = 32'hDEAD_BEEF;
    bmem[32'h1000_0004 >> 2]    = 32'hDEAD_BEEF;
    rd_op(32'h1000_0004, 20, lat);
    check("rd_latency", 68'(lat), 68'(3));

    // Same-cycle grant and data goes straight to the response.
    rl_fixed = 0;
    rd_op(32'h1000_0008, 20, lat);
    check("rd_latency_fast", 68'(lat), 68'(2));

    // Fill the buffer with grants held off; the fifth write must stall.
    gnt_mode = 0; rl_fixed = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      wr_try(32'h0000_0400 + 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i), acc);
      check("fill_ready", 68'(acc), 68'(i < 4));
    end
    repeat (2) begin
      step();
      wr_try(32'h0000_0410, 4'hF, 32'hC0DE_0004, acc);
      check("full_ready", 68'(acc), 68'(1'b0));
    end
    gnt_mode = 1;
    wr_wait(32'h0000_0410, 4'hF, 32'hC0DE_0004, 20);
    wait_drain(30);

    // Pop and push together while the buffer is under pressure.
    gnt_mode = 0;
    for (int i = 0; i < 4; i++) wr_wait(32'h0000_0500 + 32'(i * 4), 4'h3, 32'hAB00 + 32'(i), 10);
    step(); wr_try(32'h0000_0510, 4'hC, 32'h1234_5678, acc);
    check("pp_full_a", 68'(acc), 68'(1'b0));
    gnt_mode = 1;
    step(); wr_try(32'h0000_0510, 4'hC, 32'h1234_5678, acc);
    check("pp_full_b", 68'(acc), 68'(1'b0));
    step(); wr_try(32'h0000_0510, 4'hC, 32'h1234_5678, acc);
    check("pp_push_pop", 68'(acc), 68'(1'b1));
    gnt_mode = 0;
    step(); idle();
    check("pp_occ", 68'(dut.u_wbuf.occ), 68'(exp_wr.size()));
    step(); wr_try(32'h0000_0514, 4'hF, 32'h9999_0001, acc);
    check("pp_refill", 68'(acc), 68'(1'b1));
    step(); wr_try(32'h0000_0518, 4'hF, 32'h9999_0002, acc);
    check("pp_full_again", 68'(acc), 68'(1'b0));
    check("pp_occ_full", 68'(dut.u_wbuf.occ), 68'(exp_wr.size()));
    gnt_mode = 1;
    wr_wait(32'h0000_0518, 4'hF, 32'h9999_0002, 20);
    wait_drain(30);

    // Read after write: read held until the write has gone out first.
    gnt_mode = 0;
    wr_wait(32'h0000_0020, 4'b0001, 32'h0000_00AA, 10);
    step(); req_valid = 1; req_op = 0; req_addr = 32'h0000_0020; #1;
    check("raw_held", 68'(rdy), 68'(1'b0));
    step(); #1;
    check("raw_held2", 68'(rdy), 68'(1'b0));
    gnt_mode = 1;
    rd_op(32'h0000_0020, 20, lat);
    check("raw_order", 68'(wr_gnt_cyc < rd_gnt_cyc), 68'(1'b1));
    check("raw_model", 68'(ref_rd(32'h20)), 68'(merge(dflt(32'h20), 32'hAA, 4'b0001)));

    // Reset while waiting for read data; the late data must be ignored.
    rl_fixed = 4;
    step(); req_valid = 1; req_op = 0; req_addr = 32'h0000_0300; #1;
    check("rstrd_accept", 68'(rdy), 68'(1'b1));
    exp_rdaddr.push_back(32'h0000_0300);
    step(); idle();
    step(); reset = 1;
    step(); reset = 0; #1;
    check("rstrd_ready", 68'(rdy), 68'(1'b1));
    repeat (6) begin
      step();
      check("rstrd_no_rvalid", 68'(rvld), 68'(1'b0));
      check("rstrd_rdata", 68'(rdata), 68'(0));
      check("rstrd_no_req", 68'(mem_req), 68'(1'b0));
    end
    rl_fixed = 1;

    // Reset with writes still buffered discards them.
    gnt_mode = 0;
    for (int i = 0; i < 2; i++) wr_wait(32'hF000_0000 + 32'(i * 4), 4'hF, 32'hBAD0 + 32'(i), 10);
    check("rstwr_pending", 68'(mem_req), 68'(1'b1));
    step(); reset = 1;
    step(); reset = 0;
    for (int i = 0; i < 2; i++) ref_mem.delete((32'hF000_0000 + 32'(i * 4)) >> 2);
    exp_wr.delete();
    gnt_mode = 1;
    repeat (3) begin
      step();
      check("rstwr_dropped", 68'(mem_req), 68'(1'b0));
    end

    // Cache op: accepted in IDLE even with a buffered write blocking reads.
    gnt_mode = 0;
    wr_wait(32'h0000_0040, 4'hF, 32'h0101_0101, 10);
    step(); req_valid = 0; req_op = 0; #1;
    check("cacop_read_blocked", 68'(rdy), 68'(1'b0));
    req_valid = 1; req_cacop = 1; req_cacop_code = 2'd2; req_cacop_addr = 32'h40; #1;
    check("cacop_ready_busy", 68'(rdy), 68'(1'b1));
    step(); idle();
    gnt_mode = 1;
    wait_drain(20);
    step(); req_valid = 1; req_cacop = 1; req_op = 0; #1;
    check("cacop_ready", 68'(rdy), 68'(1'b1));
    step(); idle();
    repeat (3) begin
      check("cacop_no_req", 68'(mem_req), 68'(1'b0));
      check("cacop_no_rvalid", 68'(rvld), 68'(1'b0));
      step();
    end

    // Randomized mix against the program-order model.
    gnt_mode = 2; rl_fixed = -1;
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = 32'h0000_0100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if (kind < 4) wr_wait(a, 4'($urandom_range(1, 15)), $urandom, 40);
      else if (kind < 8) rd_op(a, 40, lat);
      else if (kind == 8) begin
        step(); req_valid = 1; req_cacop = 1; req_op = 1'($urandom); #1;
        check("rnd_cacop_ready", 68'(rdy), 68'(1'b1));
        step(); idle();
      end else repeat ($urandom_range(1, 3)) step();
    end
    wait_drain(60);
    check("end_wr_queue", 68'(exp_wr.size()), 68'(0));
    check("end_rd_queue", 68'(exp_rdaddr.size()), 68'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
